dlv_skew_ctrl: RTL



---
 rtl/dlv_skew_pkg.sv | 20 ++
 rtl/dlv_win_cnt.sv | 43 ++++
 rtl/dlv_skew_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/dlv_skew_pkg.sv
// Shared types for the serdes odd/even half-word skew controller.
package dlv_skew_pkg;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [1:0] MODE_PASS     = 2'd0;
  localparam logic [1:0] MODE_DLY_EVEN = 2'd1;
  localparam logic [1:0] MODE_DLY_ODD  = 2'd2;

  function automatic logic [1:0] next_mode(input logic [1:0] m);
    if (m == MODE_PASS)          return MODE_DLY_EVEN;
    else if (m == MODE_DLY_EVEN) return MODE_DLY_ODD;
    else                         return MODE_PASS;
  endfunction

endpackage

// File: rtl/dlv_win_cnt.sv
// Sample/bad-sample window counter with limit compare; fail and win_end
// look ahead by including the sample presented this cycle.
module dlv_win_cnt #(
  parameter int WINDOW = 64
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        valid,
  input  logic        ok,
  input  logic [31:0] lim,
  output logic        fail,
  output logic        win_end
);

  localparam int CW = $clog2(WINDOW + 1);

  logic [CW-1:0] smp_cnt;
  logic [CW-1:0] bad_cnt;
  logic [CW-1:0] smp_inc;
  logic [CW-1:0] bad_inc;

  assign smp_inc = smp_cnt + CW'(1);
  assign bad_inc = bad_cnt + CW'(!ok);

  assign fail    = en & valid & !ok & (32'(bad_inc) > lim);
  assign win_end = en & valid & (32'(smp_inc) == 32'(WINDOW));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      smp_cnt <= '0;
      bad_cnt <= '0;
    end else if (clr) begin
      smp_cnt <= '0;
      bad_cnt <= '0;
    end else if (en & valid) begin
      smp_cnt <= smp_inc;
      bad_cnt <= bad_inc;
    end
  end

endmodule

// File: rtl/dlv_skew_ctrl.sv
// Odd/even half-word delay mode controller: hunts for clean framing across
// the three delay modes, holds lock, and honours software force/restart.
module dlv_skew_ctrl
  import dlv_skew_pkg::*;
#(
  parameter int WINDOW     = 64,
  parameter int BAD_LIMIT  = 0,
  parameter int LOSS_LIMIT = 8,
  parameter int SETTLE     = 8
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       chk_valid,
  input  logic       chk_ok,
  input  logic       force_en,
  input  logic [1:0] force_mode,
  input  logic       restart,
  output logic [1:0] mode,
  output logic       mode_change,
  output logic       locked,
  output logic [7:0] sweeps
);

  localparam int SW = $clog2(SETTLE + 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t        state;
  logic [SW-1:0] settle_cnt;
  logic [1:0]    eff_force;
  logic [1:0]    rst_mode;
  logic          force_mis;
  logic          win_fail;
  logic          win_end;
  logic          win_clr;
  logic [31:0]   win_lim;

  assign eff_force = (force_mode == 2'd3) ? MODE_PASS : force_mode;
  assign rst_mode  = force_en ? eff_force : MODE_PASS;
  assign force_mis = force_en & (mode != eff_force);
  assign win_lim   = (state == ST_LOCKED) ? 32'(LOSS_LIMIT) : 32'(BAD_LIMIT);
  // Counters restart on every state transition and at each locked window end.
  assign win_clr   = restart | force_mis | (state == ST_SETTLE) | win_fail | win_end;

  dlv_win_cnt #(.WINDOW(WINDOW)) u_win (
    .clk     (clk),
    .arst_n  (arst_n),
    .clr     (win_clr),
    .en      (state != ST_SETTLE),
    .valid   (chk_valid),
    .ok      (chk_ok),
    .lim     (win_lim),
    .fail    (win_fail),
    .win_end (win_end)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= ST_SETTLE;
      settle_cnt  <= SW'(SETTLE);
      mode        <= MODE_PASS;
      mode_change <= 1'b0;
      locked      <= 1'b0;
      sweeps      <= 8'd0;
    end else begin
      mode_change <= 1'b0;
      if (restart) begin
        mode        <= rst_mode;
        mode_change <= (rst_mode != mode);
        locked      <= 1'b0;
        state       <= ST_SETTLE;
        settle_cnt  <= SW'(SETTLE);
      end else if (force_mis) begin
        mode        <= eff_force;
        mode_change <= 1'b1;
        locked      <= 1'b0;
        state       <= ST_SETTLE;
        settle_cnt  <= SW'(SETTLE);
      end else begin
        case (state)
          ST_SETTLE: begin
            if (settle_cnt == SW'(1)) state <= ST_HUNT;
            else                      settle_cnt <= settle_cnt - SW'(1);
          end
          ST_HUNT: begin
            if (win_fail) begin
              if (!force_en) begin
                mode        <= next_mode(mode);
                mode_change <= 1'b1;
                if (mode == MODE_DLY_ODD) sweeps <= sat_inc8(sweeps);
              end
              state      <= ST_SETTLE;
              settle_cnt <= SW'(SETTLE);
            end else if (win_end) begin
              state  <= ST_LOCKED;
              locked <= 1'b1;
            end
          end
          ST_LOCKED: begin
            if (win_fail) begin
              locked     <= 1'b0;
              state      <= ST_SETTLE;
              settle_cnt <= SW'(SETTLE);
            end
          end
          default: begin
            state      <= ST_SETTLE;
            settle_cnt <= SW'(SETTLE);
          end
        endcase
      end
    end
  end

endmodule
